// File: rtl/prog_updown_counter_p.sv
// Programmable up/down triangle counter with a chip-select register bus.
// Counts PLR -> ULR -> LLR -> PLR (or the mirrored order) for CCR cycles or continuously.
module prog_updown_counter_p #(
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ncs,
    input  logic             nwr,
    input  logic             nrd,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_en,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] cout,
    output logic             dir,
    output logic             err,
    output logic             ec,
    output logic             busy
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UP_ULR    = 3'd1,
        DOWN_LLR  = 3'd2,
        UP_PLR    = 3'd3,
        DOWN_LLR0 = 3'd4,
        UP_ULR0   = 3'd5,
        DOWN_PLR  = 3'd6
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_plr, r_ulr, r_llr, r_cout, r_dout;
    logic [CWIDTH-1:0]   r_ccr, r_rem;
    logic [1:0]          r_ctrl;
    logic                r_dir, r_err, r_ec, r_busy, r_dout_en, r_start_d;

    state_t              w_state_nxt, w_first;
    logic [WIDTH-1:0]    w_cout_nxt, w_step, w_rdata;
    logic [CWIDTH-1:0]   w_rem_nxt;
    logic [3:0]          w_pre, w_post;
    logic                w_dir_nxt, w_ec_nxt, w_busy_nxt, w_up, w_end, w_start_edge;
    logic                w_wr, w_rd;

    function automatic logic [WIDTH-1:0] f_target(input state_t s);
        case (s)
            UP_ULR, UP_ULR0:     f_target = r_ulr;
            DOWN_LLR, DOWN_LLR0: f_target = r_llr;
            default:             f_target = r_plr;
        endcase
    endfunction

    function automatic state_t f_next(input state_t s);
        case (s)
            UP_ULR:    f_next = DOWN_LLR;
            DOWN_LLR:  f_next = UP_PLR;
            DOWN_LLR0: f_next = UP_ULR0;
            UP_ULR0:   f_next = DOWN_PLR;
            default:   f_next = s;
        endcase
    endfunction

    function automatic logic f_is_up(input state_t s);
        f_is_up = (s == UP_ULR) || (s == UP_PLR) || (s == UP_ULR0);
    endfunction

    // Walks past phases whose target is already reached; bit 3 flags a closed cycle.
    function automatic logic [3:0] f_resolve(input state_t s, input logic [WIDTH-1:0] v);
        state_t p;
        logic   e;
        p = s;
        e = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!e && (p != IDLE) && (v == f_target(p))) begin
                if ((p == UP_PLR) || (p == DOWN_PLR)) e = 1'b1;
                else p = f_next(p);
            end else begin
                e = e;
            end
        end
        f_resolve = {e, p};
    endfunction

    assign w_wr         = !ncs && !nwr;
    assign w_rd         = !ncs && !nrd && nwr;
    assign w_start_edge = start && !r_start_d;
    assign w_first      = r_ctrl[1] ? DOWN_LLR0 : UP_ULR;

    // Read-data multiplexer
    always_comb begin
        w_rdata = {WIDTH{1'b0}};
        case (addr)
            3'd0:    w_rdata = r_plr;
            3'd1:    w_rdata = r_ulr;
            3'd2:    w_rdata = r_llr;
            3'd3:    w_rdata = WIDTH'(r_ccr);
            3'd4:    w_rdata = {{(WIDTH-2){1'b0}}, r_ctrl};
            3'd5:    w_rdata = WIDTH'(r_rem);
            3'd6:    w_rdata = r_cout;
            default: w_rdata = {WIDTH{1'b0}};
        endcase
    end

    // Counter next-state: pre-resolve zero-length phases, step once, then detect cycle close
    always_comb begin
        w_state_nxt = r_state;
        w_cout_nxt  = r_cout;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = 1'b0;
        w_ec_nxt    = 1'b0;
        w_busy_nxt  = r_busy;
        w_pre       = f_resolve(r_state, r_cout);
        w_up        = f_is_up(state_t'(w_pre[2:0]));
        w_step      = w_up ? (r_cout + WIDTH'(1)) : (r_cout - WIDTH'(1));
        w_post      = f_resolve(state_t'(w_pre[2:0]), w_step);
        w_end       = w_pre[3] || w_post[3];
        case (r_state)
            IDLE: begin
                if (w_start_edge && !r_err) begin
                    if ((r_ccr == {CWIDTH{1'b0}}) && !r_ctrl[0]) begin
                        w_ec_nxt = 1'b1;
                    end else begin
                        w_state_nxt = w_first;
                        w_cout_nxt  = r_plr;
                        w_rem_nxt   = r_ccr;
                        w_busy_nxt  = 1'b1;
                    end
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            default: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    if (w_pre[3]) begin
                        w_dir_nxt = r_dir;
                    end else begin
                        w_cout_nxt = w_step;
                        w_dir_nxt  = w_up;
                    end
                    w_state_nxt = w_end ? w_first : state_t'(w_post[2:0]);
                    if (w_end && !r_ctrl[0]) begin
                        w_rem_nxt = r_rem - CWIDTH'(1);
                        if (r_rem == CWIDTH'(1)) begin
                            w_ec_nxt    = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_ec_nxt = 1'b0;
                        end
                    end else begin
                        w_rem_nxt = r_rem;
                    end
                end
            end
        endcase
    end

    // State, configuration, bus and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_plr     <= WIDTH'(1);
            r_ulr     <= {WIDTH{1'b1}};
            r_llr     <= {WIDTH{1'b0}};
            r_ccr     <= {CWIDTH{1'b0}};
            r_ctrl    <= 2'b00;
            r_rem     <= {CWIDTH{1'b0}};
            r_cout    <= {WIDTH{1'b0}};
            r_dir     <= 1'b0;
            r_ec      <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= {WIDTH{1'b0}};
            r_dout_en <= 1'b0;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cout    <= w_cout_nxt;
            r_rem     <= w_rem_nxt;
            r_dir     <= w_dir_nxt;
            r_ec      <= w_ec_nxt;
            r_busy    <= w_busy_nxt;
            r_start_d <= start;
            r_err     <= (r_plr < r_llr) || (r_plr > r_ulr);
            if (w_wr && !r_busy) begin
                case (addr)
                    3'd0:    r_plr  <= din;
                    3'd1:    r_ulr  <= din;
                    3'd2:    r_llr  <= din;
                    3'd3:    r_ccr  <= CWIDTH'(din);
                    3'd4:    r_ctrl <= din[1:0];
                    default: r_ctrl <= r_ctrl;
                endcase
            end else begin
                r_ctrl <= r_ctrl;
            end
            r_dout_en <= w_rd;
            r_dout    <= w_rd ? w_rdata : r_dout;
        end
    end

    assign cout    = r_cout;
    assign dir     = r_dir;
    assign err     = r_err;
    assign ec      = r_ec;
    assign busy    = r_busy;
    assign dout    = r_dout;
    assign dout_en = r_dout_en;

endmodule

// File: tb/tb_prog_updown_counter_p.sv
// Directed self-checking bench for prog_updown_counter_p (8-bit and 12-bit builds side by side).
module tb_prog_updown_counter_p;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ncs = 1'b1, nwr = 1'b1, nrd = 1'b1;
    logic [2:0]  addr = 3'd0;
    logic [11:0] din = 12'd0;
    logic        start = 1'b0, stop = 1'b0;

    logic [7:0]  dout8, cout8;
    logic        dout_en8, dir8, err8, ec8, busy8;
    logic [11:0] dout12, cout12;
    logic        dout_en12, dir12, err12, ec12, busy12;

    int n_asserts = 0;
    int n_fail    = 0;

    int exp_c2[8]  = '{4, 5, 4, 3, 2, 1, 2, 3};
    int exp_d2[8]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    int exp_c3[16] = '{2, 1, 2, 3, 4, 5, 4, 3, 2, 1, 2, 3, 4, 5, 4, 3};
    int exp_d3[16] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp_c7[4]  = '{256, 257, 256, 255};

    always #5 clk = ~clk;

    prog_updown_counter_p #(.WIDTH(8), .CWIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .ncs(ncs), .nwr(nwr), .nrd(nrd), .addr(addr),
        .din(din[7:0]), .dout(dout8), .dout_en(dout_en8), .start(start), .stop(stop),
        .cout(cout8), .dir(dir8), .err(err8), .ec(ec8), .busy(busy8)
    );

    prog_updown_counter_p #(.WIDTH(12), .CWIDTH(8)) dut12 (
        .clk(clk), .reset(reset), .ncs(ncs), .nwr(nwr), .nrd(nrd), .addr(addr),
        .din(din), .dout(dout12), .dout_en(dout_en12), .start(start), .stop(stop),
        .cout(cout12), .dir(dir12), .err(err12), .ec(ec12), .busy(busy12)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] d);
        ncs = 1'b0; nwr = 1'b0; addr = a; din = d;
        tick();
        ncs = 1'b1; nwr = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        ncs = 1'b0; nrd = 1'b0; addr = a;
        tick();
        ncs = 1'b1; nrd = 1'b1;
        check_eq(tag, dout8, exp);
        check_eq({tag, "_en"}, dout_en8, 1);
        tick();
        check_eq({tag, "_en_off"}, dout_en8, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n_ec;
        // Reset state and register readback
        tick(); tick();
        reset = 1'b1;
        check_eq("rst_cout", cout8, 0);
        check_eq("rst_busy", busy8, 0);
        check_eq("rst_dir", dir8, 0);
        check_eq("rst_ec", ec8, 0);
        check_eq("rst_dout", dout8, 0);
        check_eq("rst_dout_en", dout_en8, 0);
        tick();
        check_eq("rst_err", err8, 0);
        rd_chk("rd_plr", 3'd0, 1);
        ncs = 1'b0; nrd = 1'b0; addr = 3'd1;
        tick();
        ncs = 1'b1; nrd = 1'b1;
        check_eq("rd_ulr", dout8, 255);
        check_eq("rd_ulr12", dout12, 4095);
        rd_chk("rd_llr", 3'd2, 0);
        rd_chk("rd_ccr", 3'd3, 0);

        // One normal-order cycle
        wr(3'd0, 12'd3); wr(3'd1, 12'd5); wr(3'd2, 12'd1); wr(3'd3, 12'd1);
        tick();
        pulse_start();
        check_eq("n_start_cout", cout8, 3);
        check_eq("n_start_busy", busy8, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("n_cout%0d", i), cout8, exp_c2[i]);
            check_eq($sformatf("n_dir%0d", i), dir8, exp_d2[i]);
            check_eq($sformatf("n_ec%0d", i), ec8, (i == 7) ? 1 : 0);
            check_eq($sformatf("n_busy%0d", i), busy8, (i == 7) ? 0 : 1);
        end
        tick();
        check_eq("n_after_ec", ec8, 0);
        check_eq("n_after_cout", cout8, 3);
        check_eq("n_after_dir", dir8, 0);

        // Down-first, two cycles, REMAIN sampled mid-run
        wr(3'd4, 12'd2); wr(3'd3, 12'd2);
        pulse_start();
        check_eq("d_start_cout", cout8, 3);
        n_ec = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 9) begin
                ncs = 1'b0; nrd = 1'b0; addr = 3'd5;
            end
            tick();
            ncs = 1'b1; nrd = 1'b1;
            if (i == 9) check_eq("d_remain", dout8, 1);
            if (ec8) n_ec++;
            check_eq($sformatf("d_cout%0d", i), cout8, exp_c3[i]);
            check_eq($sformatf("d_dir%0d", i), dir8, exp_d3[i]);
        end
        check_eq("d_ec_last", ec8, 1);
        check_eq("d_ec_count", n_ec, 1);
        check_eq("d_busy_end", busy8, 0);

        // Configuration error blocks start; CCR=0 completes immediately
        wr(3'd4, 12'd0);
        wr(3'd0, 12'd0);
        check_eq("e_err_latency", err8, 0);
        tick();
        check_eq("e_err", err8, 1);
        pulse_start();
        check_eq("e_start_busy", busy8, 0);
        check_eq("e_start_ec", ec8, 0);
        check_eq("e_start_cout", cout8, 3);
        wr(3'd0, 12'd3); wr(3'd3, 12'd0);
        tick();
        check_eq("z_err", err8, 0);
        pulse_start();
        check_eq("z_ec", ec8, 1);
        check_eq("z_busy", busy8, 0);
        check_eq("z_cout", cout8, 3);
        tick();
        check_eq("z_ec_off", ec8, 0);

        // Continuous mode: blocked write, then stop
        wr(3'd4, 12'd1);
        pulse_start();
        check_eq("c_start_cout", cout8, 3);
        wr(3'd0, 12'd9);
        check_eq("c_cout4", cout8, 4);
        rd_chk("c_plr_kept", 3'd0, 3);
        check_eq("c_cout4b", cout8, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("s_busy", busy8, 0);
        check_eq("s_cout", cout8, 4);
        check_eq("s_ec", ec8, 0);
        tick();
        check_eq("s_hold", cout8, 4);
        pulse_start();
        check_eq("c_restart", cout8, 3);
        for (int i = 0; i < 8; i++) tick();
        check_eq("c_wrap_cout", cout8, 3);
        check_eq("c_wrap_busy", busy8, 1);
        check_eq("c_wrap_ec", ec8, 0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("r_cout", cout8, 0);
        check_eq("r_busy", busy8, 0);
        tick();
        check_eq("r_cout_held", cout8, 0);
        rd_chk("r_plr", 3'd0, 1);
        rd_chk("r_ctrl", 3'd4, 0);

        // 12-bit build counting across 255 -> 256
        wr(3'd0, 12'd255); wr(3'd1, 12'd257); wr(3'd2, 12'd255); wr(3'd3, 12'd1);
        tick();
        check_eq("w_err12", err12, 0);
        pulse_start();
        check_eq("w_start12", cout12, 255);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("w_cout%0d", i), cout12, exp_c7[i]);
        end
        check_eq("w_ec12", ec12, 1);
        check_eq("w_busy12", busy12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
